// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data memory: funct3 access sizes,
// controller state encoding, the all-zero word and an index-width helper.
package dmem_pkg;

    // RV32 load/store funct3 encodings
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    // Controller states: post-reset zero sweep, then normal operation
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } dmem_state_t;

    localparam logic [31:0] ZERO_WORD = '0;

    // Ceiling log2, used to size the word index
    function automatic int unsigned clog2(input int unsigned value);
        for (int unsigned r = 0; r < 32; r++) begin
            if ((64'd1 << r) >= 64'(value)) return r;
        end
        return 32;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32 loads and stores: store byte mask, replicated
// store data, extended load data and the alignment error flag.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wrep_o,
    output logic [31:0] ldata_o,
    output logic        misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Decode size/offset into lane mask, replicated write data and extended read data
    always_comb begin
        be_o       = '0;
        wrep_o     = wdata_i;
        ldata_o    = '0;
        misalign_o = 1'b0;
        byte_sel   = rword_i[{off_i, 3'b000} +: 8];
        half_sel   = off_i[1] ? rword_i[31:16] : rword_i[15:0];
        case (size_i)
            SZ_B: begin
                be_o    = 4'b0001 << off_i;
                wrep_o  = {4{wdata_i[7:0]}};
                ldata_o = {{24{byte_sel[7]}}, byte_sel};
            end
            SZ_BU: begin
                ldata_o = {24'd0, byte_sel};
            end
            SZ_H: begin
                be_o       = 4'b0011 << off_i;
                wrep_o     = {2{wdata_i[15:0]}};
                ldata_o    = {{16{half_sel[15]}}, half_sel};
                misalign_o = off_i[0];
            end
            SZ_HU: begin
                ldata_o    = {16'd0, half_sel};
                misalign_o = off_i[0];
            end
            SZ_W: begin
                be_o       = 4'b1111;
                ldata_o    = rword_i;
                misalign_o = (off_i != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory for the RV32 MEM stage: byte/half/word accesses with latency-1
// responses, error flagging and a zero sweep after reset.
// Optional macro DMEM_WATCH_EN adds watch_0_o/watch_1_o debug taps on words
// DEPTH-5 and DEPTH-6.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_100MHz,
    input  logic              arst,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [2:0]        size_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              ready_o,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
`ifdef DMEM_WATCH_EN
    output logic [DATA_W-1:0] watch_0_o,
    output logic [DATA_W-1:0] watch_1_o,
`endif
    output logic              err_o
);

    localparam int unsigned IDXW = clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    dmem_state_t       state_q;
    logic [IDXW-1:0]   clr_idx_q;
    logic              ready_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic [IDXW-1:0]   idx;
    logic [1:0]        off;
    logic [3:0]        be;
    logic [DATA_W-1:0] wrep;
    logic [DATA_W-1:0] ldata;
    logic              misalign;
    logic              acc;
    logic              wr_en;
    logic              err_d;
    logic [DATA_W-1:0] rdata_d;

    assign idx = addr_i[IDXW+1:2];
    assign off = addr_i[1:0];

    dmem_lane_align u_lane (
        .size_i     (size_i),
        .off_i      (off),
        .wdata_i    (wdata_i),
        .rword_i    (mem_q[idx]),
        .be_o       (be),
        .wrep_o     (wrep),
        .ldata_o    (ldata),
        .misalign_o (misalign)
    );

    // Acceptance, error classification and next response data
    always_comb begin
        acc     = req_i && ready_q;
        err_d   = (size_i == 3'b011) || (size_i == 3'b110) || (size_i == 3'b111)
                  || misalign
                  || ((addr_i >> (IDXW + 2)) != '0)
                  || (we_i && ((size_i == SZ_BU) || (size_i == SZ_HU)));
        rdata_d = (err_d || we_i) ? ZERO_WORD : ldata;
        wr_en   = acc && we_i && !err_d;
    end

    // Controller: clear sweep, then one registered response per accepted request
    always_ff @(posedge clk_100MHz or posedge arst) begin
        if (arst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            unique case (state_q)
                ST_CLEAR: begin
                    clr_idx_q <= clr_idx_q + IDXW'(1);
                    if (clr_idx_q == IDXW'(DEPTH - 1)) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (acc) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= rdata_d;
                        err_q    <= err_d;
                    end
                end
            endcase
        end
    end

    // Storage array: sweep writes zero, stores update only masked lanes
    always_ff @(posedge clk_100MHz) begin
        if (state_q == ST_CLEAR) begin
            mem_q[clr_idx_q] <= ZERO_WORD;
        end else if (wr_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) mem_q[idx][8*b +: 8] <= wrep[8*b +: 8];
            end
        end
    end

    assign ready_o  = ready_q;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

`ifdef DMEM_WATCH_EN
    assign watch_0_o = (state_q == ST_IDLE) ? mem_q[DEPTH-5] : ZERO_WORD;
    assign watch_1_o = (state_q == ST_IDLE) ? mem_q[DEPTH-6] : ZERO_WORD;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus random traffic
// against a byte-addressed reference memory.
module tb_dmem_ctrl;

    localparam int unsigned DEPTH  = 64;
    localparam int unsigned ADDR_W = 32;

    logic        clk_100MHz = 1'b0;
    logic        arst       = 1'b1;
    logic        req_i      = 1'b0;
    logic        we_i       = 1'b0;
    logic [2:0]  size_i     = 3'b010;
    logic [31:0] addr_i     = '0;
    logic [31:0] wdata_i    = '0;
    logic        ready_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
`ifdef DMEM_WATCH_EN
    logic [31:0] watch_0_o;
    logic [31:0] watch_1_o;
`endif

    always #5 clk_100MHz = ~clk_100MHz;

    dmem_ctrl #(
        .DATA_W (32),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .arst       (arst),
        .req_i      (req_i),
        .we_i       (we_i),
        .size_i     (size_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .ready_o    (ready_o),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
`ifdef DMEM_WATCH_EN
        .watch_0_o  (watch_0_o),
        .watch_1_o  (watch_1_o),
`endif
        .err_o      (err_o)
    );

    byte unsigned ref_mem [DEPTH*4];
    int          checks     = 0;
    int          failures   = 0;
    logic        exp_ready  = 1'b0;
    logic [31:0] last_rdata = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err(input logic we, input logic [2:0] sz, input logic [31:0] a);
        if (sz == 3 || sz == 6 || sz == 7) return 1'b1;
        if ((sz == 1 || sz == 5) && (a % 2 != 0)) return 1'b1;
        if (sz == 2 && (a % 4 != 0)) return 1'b1;
        if (a >= DEPTH * 4) return 1'b1;
        if (we && (sz == 4 || sz == 5)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_word(input int unsigned w);
        return ref_mem[4*w] + 32'd256 * ref_mem[4*w+1] + 32'd65536 * ref_mem[4*w+2]
               + 32'd16777216 * ref_mem[4*w+3];
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] sz, input logic [31:0] a);
        logic [31:0] v;
        v = '0;
        case (sz)
            3'd0: begin v = ref_mem[a]; if (v >= 128) v = v + 32'hFFFF_FF00; end
            3'd4: v = ref_mem[a];
            3'd1: begin v = ref_mem[a] + 32'd256 * ref_mem[a+1]; if (v >= 32768) v = v + 32'hFFFF_0000; end
            3'd5: v = ref_mem[a] + 32'd256 * ref_mem[a+1];
            3'd2: v = model_word(a / 4);
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic model_store(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int unsigned n;
        n = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
        for (int unsigned k = 0; k < n; k++) ref_mem[a+k] = 8'(wd >> (8*k));
    endtask

    // One clock cycle: present a request, predict, then check the response after the edge
    task automatic step(input logic rq, input logic we, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input string tag);
        logic        acc;
        logic        e;
        logic [31:0] rd;
        req_i = rq; we_i = we; size_i = sz; addr_i = a; wdata_i = wd;
        check({tag, ":ready"}, ready_o, exp_ready);
        acc = rq && exp_ready;
        e   = 1'b0;
        rd  = '0;
        if (acc) begin
            e = model_err(we, sz, a);
            if (!e && !we) rd = model_load(sz, a);
            if (!e && we)  model_store(sz, a, wd);
        end
        @(posedge clk_100MHz); #1;
        check({tag, ":rvalid"}, rvalid_o, acc);
        if (acc) begin
            check({tag, ":err"}, err_o, e);
            check({tag, ":rdata"}, rdata_o, rd);
            last_rdata = rd;
        end else begin
            check({tag, ":hold"}, rdata_o, last_rdata);
        end
`ifdef DMEM_WATCH_EN
        check({tag, ":watch0"}, watch_0_o, model_word(DEPTH-5));
        check({tag, ":watch1"}, watch_1_o, model_word(DEPTH-6));
`endif
        req_i = 1'b0;
    endtask

    // Assert reset (outputs must drop at once), hold two edges, release
    task automatic reset_pulse(input string tag);
        arst = 1'b1;
        #1;
        check({tag, ":rst_ready"}, ready_o, 1'b0);
        check({tag, ":rst_rvalid"}, rvalid_o, 1'b0);
        check({tag, ":rst_rdata"}, rdata_o, 32'h0);
        check({tag, ":rst_err"}, err_o, 1'b0);
`ifdef DMEM_WATCH_EN
        check({tag, ":rst_watch0"}, watch_0_o, 32'h0);
`endif
        @(posedge clk_100MHz); #1;
        @(posedge clk_100MHz); #1;
        arst = 1'b0;
        for (int unsigned i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h00;
        last_rdata = '0;
        exp_ready  = 1'b0;
    endtask

    // With req_i held high, count cycles until ready_o rises (bounded)
    task automatic measure_clear(input string tag);
        int unsigned cnt;
        logic        rv_seen;
        cnt = 0;
        rv_seen = 1'b0;
        req_i = 1'b1; we_i = 1'b0; size_i = 3'b010; addr_i = 32'h0;
        while (ready_o !== 1'b1 && cnt < 200) begin
            if (rvalid_o !== 1'b0) rv_seen = 1'b1;
            cnt++;
            @(posedge clk_100MHz); #1;
        end
        req_i = 1'b0;
        check({tag, ":clear_len"}, cnt, DEPTH);
        check({tag, ":clear_rvalid"}, rv_seen, 1'b0);
        check({tag, ":clear_rdata"}, rdata_o, 32'h0);
        exp_ready = 1'b1;
    endtask

    initial begin
        logic [2:0]  sz;
        logic [31:0] a;

        // 1. Reset and full sweep, then every word reads zero
        reset_pulse("t1");
        measure_clear("t1");
        for (int unsigned w = 0; w < DEPTH; w++) step(1, 0, 3'b010, 4*w, 0, "t1_zero");

        // 2. Sign/zero extension
        step(1, 1, 3'b010, 32'h10, 32'h8000_00F4, "t2_sw");
        step(1, 0, 3'b000, 32'h10, 0, "t2_lb");
        check("t2_lb_const", rdata_o, 32'hFFFF_FFF4);
        step(1, 0, 3'b100, 32'h10, 0, "t2_lbu");
        check("t2_lbu_const", rdata_o, 32'h0000_00F4);
        step(1, 0, 3'b001, 32'h12, 0, "t2_lh");
        check("t2_lh_const", rdata_o, 32'hFFFF_8000);
        step(1, 0, 3'b101, 32'h12, 0, "t2_lhu");
        check("t2_lhu_const", rdata_o, 32'h0000_8000);

        // 3. Back-to-back store/store/load with read-after-write
        step(1, 1, 3'b010, 32'h20, 32'h1122_3344, "t3_sw");
        step(1, 1, 3'b000, 32'h21, 32'h0000_00AA, "t3_sb");
        step(1, 0, 3'b010, 32'h20, 0, "t3_lw");
        check("t3_lw_const", rdata_o, 32'h1122_AA44);
        step(1, 1, 3'b001, 32'h22, 32'h0000_BEEF, "t3_sh");
        step(1, 0, 3'b010, 32'h20, 0, "t3_lw2");
        check("t3_lw2_const", rdata_o, 32'hBEEF_AA44);

        // 4. Error cases leave memory untouched
        step(1, 0, 3'b010, 32'h22, 0, "t4_lw_mis");
        step(1, 1, 3'b001, 32'h13, 32'hFFFF_FFFF, "t4_sh_mis");
        step(1, 0, 3'b010, 32'h100, 0, "t4_lw_oor");
        step(1, 0, 3'b011, 32'h10, 0, "t4_sz011");
        step(1, 1, 3'b100, 32'h10, 32'hFFFF_FFFF, "t4_sbu");
        step(1, 1, 3'b010, 32'h8000_0010, 32'hFFFF_FFFF, "t4_sw_hi");
        step(1, 0, 3'b010, 32'h10, 0, "t4_lw");
        check("t4_lw_const", rdata_o, 32'h8000_00F4);
        step(0, 0, 3'b010, 32'h0, 0, "t4_idle");

        // 6. Debug watch on word DEPTH-5
        step(1, 1, 3'b010, 32'hEC, 32'hDEAD_BEEF, "t6_sw");
`ifdef DMEM_WATCH_EN
        check("t6_watch_const", watch_0_o, 32'hDEAD_BEEF);
`endif
        step(1, 1, 3'b010, 32'hE8, 32'h0BAD_F00D, "t6_sw1");

        // Random traffic against the reference model
        for (int unsigned i = 0; i < 400; i++) begin
            sz = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) sz = ($urandom_range(0, 1) != 0) ? 3'b010 : 3'($urandom_range(0, 5));
            a = 32'($urandom_range(0, DEPTH*4 - 1));
            if ($urandom_range(0, 1) != 0) a = a & 32'hFFFF_FFFE;
            if ($urandom_range(0, 1) != 0) a = a & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0) a = $urandom | 32'h0000_0100;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, sz, a, $urandom, "rnd");
        end

        // 5. Reset mid-traffic drops the pending response; reset mid-sweep restarts it
        step(1, 0, 3'b010, 32'h10, 0, "t5_lw");
        reset_pulse("t5a");
        req_i = 1'b1;
        for (int unsigned i = 0; i < 20; i++) begin
            @(posedge clk_100MHz); #1;
            check("t5_mid_ready", ready_o, 1'b0);
            check("t5_mid_rvalid", rvalid_o, 1'b0);
        end
        reset_pulse("t5b");
        measure_clear("t5b");
        step(1, 0, 3'b010, 32'h10, 0, "t5_lw_zero");
        step(1, 0, 3'b010, 32'h20, 0, "t5_lw_zero2");
        step(1, 0, 3'b010, 32'hEC, 0, "t5_lw_zero3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
